// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller and the MIPS ALU.
//   - datapath/immediate widths
//   - ALU control codes (also decoded by the ALU itself)
//   - opcode / funct encodings understood by the controller
//   - controller state enum and immediate-extension helpers
package alu_pkg;

  localparam int DW   = 32;
  localparam int IMMW = 16;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic [DW-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(DW-IMMW){imm[IMMW-1]}}, imm};
  endfunction

  function automatic logic [DW-1:0] zext_imm(input logic [IMMW-1:0] imm);
    return {{(DW-IMMW){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle of the ALU issue controller.
//   req_*  : decoded instruction fields from register-read (valid/ready)
//   rsp_*  : captured ALU result and flags to writeback/PC-update (valid/ready)
// master = upstream/downstream pipeline side, slave = the controller.
interface alu_issue_ctrl_if import alu_pkg::*; ();

  logic            req_valid;
  logic            req_ready;
  logic [5:0]      req_opcode;
  logic [5:0]      req_funct;
  logic [DW-1:0]   req_rs_val;
  logic [DW-1:0]   req_rt_val;
  logic [IMMW-1:0] req_imm;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            rsp_br_taken;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_zero, rsp_br_taken, rsp_illegal
  );

  modport slave (
    input  req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_result, rsp_zero, rsp_br_taken, rsp_illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction decode for the ALU issue controller.
//   opcode_i/funct_i/rs_i/rt_i/imm_i : captured instruction fields
//   ctl_o    : 4-bit ALU control code
//   a_o/b_o  : ALU operands (B is rt or the extended immediate)
//   is_beq_o : instruction is beq (branch decision uses Zero)
//   illegal_o: opcode/funct not supported
module alu_op_decode import alu_pkg::*; (
  input  logic [5:0]      opcode_i,
  input  logic [5:0]      funct_i,
  input  logic [DW-1:0]   rs_i,
  input  logic [DW-1:0]   rt_i,
  input  logic [IMMW-1:0] imm_i,
  output logic [3:0]      ctl_o,
  output logic [DW-1:0]   a_o,
  output logic [DW-1:0]   b_o,
  output logic            is_beq_o,
  output logic            illegal_o
);

  // Opcode/funct to ALU control code and operand selection.
  always_comb begin
    ctl_o     = ALU_AND;
    a_o       = rs_i;
    b_o       = rt_i;
    is_beq_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  ctl_o = ALU_ADD;
          FN_SUB:  ctl_o = ALU_SUB;
          FN_AND:  ctl_o = ALU_AND;
          FN_OR:   ctl_o = ALU_OR;
          FN_SLT:  ctl_o = ALU_SLT;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        ctl_o = ALU_ADD;
        b_o   = sext_imm(imm_i);
      end
      OP_BEQ: begin
        ctl_o    = ALU_SUB;
        is_beq_o = 1'b1;
      end
      OP_SLTI: begin
        ctl_o = ALU_SLT;
        b_o   = sext_imm(imm_i);
      end
      OP_ANDI: begin
        ctl_o = ALU_AND;
        b_o   = zext_imm(imm_i);
      end
      OP_ORI: begin
        ctl_o = ALU_OR;
        b_o   = zext_imm(imm_i);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded instruction, drives control code
// and operands to the external ALU, captures ALUOut/Zero and returns a
// registered response.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : req_* request handshake, rsp_* response handshake
//   alu_ctl/a/b     : registered drive to the ALU, held outside EXEC
//   alu_out/zero    : ALU result, sampled at the end of EXEC
module alu_issue_ctrl import alu_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic [3:0]       alu_ctl,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  input  logic [DW-1:0]    alu_out,
  input  logic             alu_zero
);

  state_e          state_q, state_d;
  logic [5:0]      opcode_q, opcode_d, funct_q, funct_d;
  logic [DW-1:0]   rs_q, rs_d, rt_q, rt_d;
  logic [IMMW-1:0] imm_q, imm_d;
  logic            is_beq_q, is_beq_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_br_q, rsp_br_d;
  logic            rsp_ill_q, rsp_ill_d;

  logic [3:0]      dec_ctl_s;
  logic [DW-1:0]   dec_a_s, dec_b_s;
  logic            dec_is_beq_s, dec_illegal_s;

  alu_op_decode u_decode (
    .opcode_i  (opcode_q),
    .funct_i   (funct_q),
    .rs_i      (rs_q),
    .rt_i      (rt_q),
    .imm_i     (imm_q),
    .ctl_o     (dec_ctl_s),
    .a_o       (dec_a_s),
    .b_o       (dec_b_s),
    .is_beq_o  (dec_is_beq_s),
    .illegal_o (dec_illegal_s)
  );

  // Next-state and registered-output logic of the issue FSM.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    imm_d        = imm_q;
    is_beq_d     = is_beq_q;
    ctl_d        = ctl_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_br_d     = rsp_br_q;
    rsp_ill_d    = rsp_ill_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          opcode_d    = bus.req_opcode;
          funct_d     = bus.req_funct;
          rs_d        = bus.req_rs_val;
          rt_d        = bus.req_rt_val;
          imm_d       = bus.req_imm;
          req_ready_d = 1'b0;
          state_d     = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        // Illegal ops bypass the ALU; its drive keeps the previous values.
        if (dec_illegal_s) begin
          rsp_valid_d  = 1'b1;
          rsp_ill_d    = 1'b1;
          rsp_result_d = {DW{1'b0}};
          rsp_zero_d   = 1'b0;
          rsp_br_d     = 1'b0;
          state_d      = RESP;
        end else begin
          ctl_d    = dec_ctl_s;
          a_d      = dec_a_s;
          b_d      = dec_b_s;
          is_beq_d = dec_is_beq_s;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_ill_d    = 1'b0;
        rsp_result_d = alu_out;
        rsp_zero_d   = alu_zero;
        rsp_br_d     = is_beq_q & alu_zero;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opcode_q     <= 6'h00;
      funct_q      <= 6'h00;
      rs_q         <= {DW{1'b0}};
      rt_q         <= {DW{1'b0}};
      imm_q        <= {IMMW{1'b0}};
      is_beq_q     <= 1'b0;
      ctl_q        <= 4'b0000;
      a_q          <= {DW{1'b0}};
      b_q          <= {DW{1'b0}};
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {DW{1'b0}};
      rsp_zero_q   <= 1'b0;
      rsp_br_q     <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      funct_q      <= funct_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      imm_q        <= imm_d;
      is_beq_q     <= is_beq_d;
      ctl_q        <= ctl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_br_q     <= rsp_br_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign alu_ctl          = ctl_q;
  assign alu_a            = a_q;
  assign alu_b            = b_q;
  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_br_taken = rsp_br_q;
  assign bus.rsp_illegal  = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural MIPS ALU and a
// mnemonic-level reference model of the expected response.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  int          n_cmp = 0;
  int          n_fail = 0;

  alu_issue_ctrl_if bus_if ();

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .alu_ctl  (alu_ctl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural MIPSALU: unsigned SLT, wrapping add/sub.
  always_comb begin
    case (alu_ctl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result of an instruction, from the instruction semantics.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm,
                                output bit legal, output logic [3:0] ctl,
                                output logic [31:0] b, output logic [31:0] res,
                                output bit br);
    logic [31:0] sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    legal = 1'b1; br = 1'b0; ctl = 4'b0000; b = rt; res = 32'd0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin ctl = 4'b0010; res = rs + rt; end
          6'h22: begin ctl = 4'b0110; res = rs - rt; end
          6'h24: begin ctl = 4'b0000; res = rs & rt; end
          6'h25: begin ctl = 4'b0001; res = rs | rt; end
          6'h2A: begin ctl = 4'b0111; res = (rs < rt) ? 32'd1 : 32'd0; end
          default: legal = 1'b0;
        endcase
      end
      6'h23, 6'h2B, 6'h08: begin ctl = 4'b0010; b = sx; res = rs + sx; end
      6'h04: begin ctl = 4'b0110; res = rs - rt; br = (rs == rt); end
      6'h0A: begin ctl = 4'b0111; b = sx; res = (rs < sx) ? 32'd1 : 32'd0; end
      6'h0C: begin ctl = 4'b0000; b = zx; res = rs & zx; end
      6'h0D: begin ctl = 4'b0001; b = zx; res = rs | zx; end
      default: legal = 1'b0;
    endcase
    if (!legal) res = 32'd0;
  endfunction

  // One request from IDLE through response; returns at a negedge in IDLE.
  task automatic run_req(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input int stall, input bit poke);
    bit legal, br;
    logic [3:0] ctl;
    logic [31:0] b, res;
    model(op, fn, rs, rt, imm, legal, ctl, b, res, br);
    chk({tag, ".idle_ready"}, bus_if.req_ready, 1'b1);
    bus_if.req_opcode = op; bus_if.req_funct = fn;
    bus_if.req_rs_val = rs; bus_if.req_rt_val = rt; bus_if.req_imm = imm;
    bus_if.req_valid = 1'b1; bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".dec_ready"}, bus_if.req_ready, 1'b0);
    chk({tag, ".dec_valid"}, bus_if.rsp_valid, 1'b0);
    bus_if.req_valid = 1'b0;
    bus_if.req_rs_val = $urandom; bus_if.req_rt_val = $urandom;
    bus_if.req_imm = 16'($urandom);
    if (legal) begin
      @(negedge clk);
      chk({tag, ".exec_ctl"}, alu_ctl, ctl);
      chk({tag, ".exec_a"}, alu_a, rs);
      chk({tag, ".exec_b"}, alu_b, b);
      chk({tag, ".exec_valid"}, bus_if.rsp_valid, 1'b0);
    end
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      chk({tag, ".rsp_valid"}, bus_if.rsp_valid, 1'b1);
      chk({tag, ".rsp_result"}, bus_if.rsp_result, res);
      chk({tag, ".rsp_zero"}, bus_if.rsp_zero, legal && (res == 32'd0));
      chk({tag, ".rsp_br"}, bus_if.rsp_br_taken, br);
      chk({tag, ".rsp_illegal"}, bus_if.rsp_illegal, !legal);
      chk({tag, ".rsp_req_ready"}, bus_if.req_ready, 1'b0);
      if (s < stall) begin
        bus_if.rsp_ready = 1'b0; bus_if.req_valid = poke;
      end else begin
        bus_if.rsp_ready = 1'b1; bus_if.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, ".back_idle_valid"}, bus_if.rsp_valid, 1'b0);
    chk({tag, ".back_idle_ready"}, bus_if.req_ready, 1'b1);
    bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    int k;
    // Reset with a request pending: nothing may be accepted.
    rst_n = 1'b0;
    bus_if.req_valid = 1'b1; bus_if.req_opcode = 6'h00; bus_if.req_funct = 6'h20;
    bus_if.req_rs_val = 32'd1; bus_if.req_rt_val = 32'd2; bus_if.req_imm = 16'h0000;
    bus_if.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", bus_if.req_ready, 1'b1);
    chk("rst.rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("rst.alu_ctl", alu_ctl, 4'b0000);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.rsp_result", bus_if.rsp_result, 32'd0);
    bus_if.req_valid = 1'b0; bus_if.rsp_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst.no_accept", bus_if.req_ready, 1'b1);

    // Directed cases.
    run_req("r_add", 6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 0, 1'b0);
    chk("r_add.direct_result", bus_if.rsp_result, 32'd12);
    run_req("beq_t", 6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0010, 0, 1'b0);
    chk("beq_t.direct_br", bus_if.rsp_br_taken, 1'b1);
    run_req("beq_nt", 6'h04, 6'h00, 32'h1234, 32'h1235, 16'h0010, 0, 1'b0);
    chk("beq_nt.direct_br", bus_if.rsp_br_taken, 1'b0);
    run_req("addi", 6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFF, 0, 1'b0);
    chk("addi.direct_result", bus_if.rsp_result, 32'd9);
    run_req("ori", 6'h0D, 6'h00, 32'd0, 32'd0, 16'h8000, 0, 1'b0);
    chk("ori.direct_result", bus_if.rsp_result, 32'h8000);
    run_req("sub_zero_nobr", 6'h00, 6'h22, 32'd3, 32'd3, 16'h0000, 1, 1'b0);
    chk("sub_zero_nobr.br", bus_if.rsp_br_taken, 1'b0);
    run_req("illegal_bp", 6'h3F, 6'h00, 32'd9, 32'd9, 16'h1111, 5, 1'b1);
    run_req("slt_unsigned", 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0000, 0, 1'b0);
    run_req("add_wrap", 6'h00, 6'h20, 32'hFFFF_FFFF, 32'd2, 16'h0000, 0, 1'b0);

    // Reset during EXEC of a sub: no response, outputs return to reset values.
    bus_if.req_opcode = 6'h00; bus_if.req_funct = 6'h22;
    bus_if.req_rs_val = 32'd50; bus_if.req_rt_val = 32'd8; bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst.exec_ctl", alu_ctl, 4'b0110);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("midrst.req_ready", bus_if.req_ready, 1'b1);
    chk("midrst.alu_ctl", alu_ctl, 4'b0000);
    chk("midrst.alu_a", alu_a, 32'd0);
    chk("midrst.alu_b", alu_b, 32'd0);
    chk("midrst.result", bus_if.rsp_result, 32'd0);
    chk("midrst.flags", {bus_if.rsp_zero, bus_if.rsp_br_taken, bus_if.rsp_illegal}, 3'b000);
    repeat (3) begin
      @(negedge clk);
      chk("midrst.no_rsp", bus_if.rsp_valid, 1'b0);
    end
    run_req("after_rst", 6'h00, 6'h22, 32'd50, 32'd8, 16'h0000, 0, 1'b0);

    // Randomized instructions, including illegal encodings and backpressure.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 14);
      rs = $urandom; rt = $urandom;
      op = 6'h00; fn = 6'($urandom);
      case (k)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2A;
        5: fn = 6'h27;
        6: op = 6'h23;
        7: op = 6'h2B;
        8: begin op = 6'h04; if ($urandom_range(0, 1) == 1) rt = rs; end
        9: op = 6'h08;
        10: op = 6'h0A;
        11: op = 6'h0C;
        12: op = 6'h0D;
        13: op = 6'h02;
        default: op = 6'h3F;
      endcase
      run_req("rand", op, fn, rs, rt, 16'($urandom), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU control/operand interface in the single-cycle-to-multicycle migration.
- Accepts one decoded instruction per handshake, derives the 4-bit ALU control code and operands, and drives them to the MIPSALU instance.
- Captures the ALU result and Zero flag, then returns a registered response with branch decision and illegal-op flag.
- Sits between the register-read stage and the writeback/PC-update logic.

Parameters:
- DW, 32, datapath width. Fixed at 32 for MIPS; other values unsupported.
- IMMW, 16, immediate field width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller idle, request accepted when valid&ready
- req_opcode  in  6  instruction[31:26]
- req_funct  in  6  instruction[5:0]
- req_rs_val  in  DW  rs register value
- req_rt_val  in  DW  rt register value
- req_imm  in  IMMW  instruction[15:0]
- alu_ctl  out  4  to ALU ALUctl
- alu_a  out  DW  to ALU A
- alu_b  out  DW  to ALU B
- alu_out  in  DW  from ALU ALUOut
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DW  captured ALUOut
- rsp_zero  out  1  captured Zero
- rsp_br_taken  out  1  beq and Zero
- rsp_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. req_ready=1; rsp_valid=0; alu_ctl=4'b0000; alu_a=0; alu_b=0; rsp_result=0; rsp_zero=0; rsp_br_taken=0; rsp_illegal=0.
- Reset mid-operation aborts any in-flight request. No response is produced for it.
- State IDLE: req_ready=1. On req_valid, register opcode, funct, rs_val, rt_val and imm, then go to DECODE.
- State DECODE: req_ready=0. Compute alu_ctl, alu_a and alu_b into registers.
  - Legal: go to EXEC.
  - Illegal: go to RESP with rsp_illegal=1, rsp_result=0, rsp_zero=0, rsp_br_taken=0. The ALU is not exercised.
- State EXEC: alu_ctl, alu_a and alu_b are stable for the whole cycle. At the end-of-cycle edge, capture alu_out to rsp_result and alu_zero to rsp_zero. Set rsp_br_taken = is_beq & alu_zero. Go to RESP.
- State RESP: rsp_valid=1. All rsp_* outputs are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Latency: accept edge at T0, DECODE at T1, EXEC at T2, rsp_valid high from T3. Rate is at most one request per 4 cycles; rsp_ready held high gives back-to-back accepts every 4 cycles.
- req_ready is registered-equivalent: high only in IDLE. A request is never accepted while a response is pending.
- alu_ctl, alu_a and alu_b hold their last values outside EXEC. They do not return to 0.
- Decode map for R-type (opcode 6'h00), operands A=rs, B=rt:
  - funct 6'h20 add -> 4'b0010
  - funct 6'h22 sub -> 4'b0110
  - funct 6'h24 and -> 4'b0000
  - funct 6'h25 or -> 4'b0001
  - funct 6'h2A slt -> 4'b0111
  - Any other funct is illegal.
- Decode map for I-type, operand A=rs:
  - lw 6'h23 and sw 6'h2B: ADD, B=sign-extended imm.
  - beq 6'h04: SUB, B=rt.
  - addi 6'h08: ADD, B=sign-extended imm.
  - slti 6'h0A: SLT, B=sign-extended imm.
  - andi 6'h0C: AND, B=zero-extended imm.
  - ori 6'h0D: OR, B=zero-extended imm.
  - Any other opcode is illegal.
- Arithmetic: SLT follows the ALU's unsigned compare. The controller passes operands unmodified and does not correct signedness. Add/sub wrap modulo 2^32 with no overflow flag.
- rsp_br_taken is 0 for all non-beq ops, even when Zero=1.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), also consumed by the ALU.
  - Opcode and funct constants.
  - State enum (IDLE, DECODE, EXEC, RESP).
- One natural sub-module: alu_op_decode, combinational. Inputs: opcode, funct, rs, rt, imm. Outputs: ctl, a, b, is_beq, illegal.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, alu_ctl=0. No accept occurs while in reset.
- R-add: opcode 00, funct 20, rs=5, rt=7, rsp_ready=1 -> alu_ctl=0010 in EXEC; rsp_valid at T3; rsp_result=12, rsp_zero=0, rsp_illegal=0.
- beq taken: opcode 04, rs=rt=32'h1234 -> alu_ctl=0110, rsp_result=0, rsp_zero=1, rsp_br_taken=1. Repeat with rt=32'h1235 -> rsp_br_taken=0.
- Immediate extension:
  - addi rs=10, imm=16'hFFFF -> alu_b=32'hFFFFFFFF, rsp_result=9.
  - ori rs=0, imm=16'h8000 -> alu_b=32'h00008000, rsp_result=32'h8000.
- Illegal plus backpressure: opcode 6'h3F -> rsp_valid at T2 with rsp_illegal=1, result=0. Hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0, a new req_valid is not accepted. Release -> IDLE next cycle.
- Mid-op reset: accept sub, assert rst_n=0 during EXEC -> no rsp_valid afterward; all outputs at reset values. The next request after reset completes normally.
